march_bist_ctrl: RTL and testbench

Parametrised March C- RAM BIST controller. Successor to the fixed 4-word / 3-bit ASTRA BIST engine.
- Generalised in address width and data width.
- Adds fail logging: first failing address, element and data, plus an error counter.
- Sits between the tester/top level and RAM_module. The top level muxes RAM address, data and control onto it whenever busy=1.

---
 rtl/march_bist_pkg.sv | 39 +++
 rtl/march_bist_ctrl_addr_gen.sv | 32 +++
 rtl/march_bist_ctrl.sv | 164 ++++++++++++++++
 tb/tb_march_bist_ctrl.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/march_bist_pkg.sv
// March C- BIST shared definitions: FSM states, element op table and
// data-background generator used by march_bist_ctrl.
package march_bist_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam int unsigned NUM_ELEM = 6;

  // Elements M1..M4 carry a read followed by a write; M0 and M5 carry one op.
  function automatic logic elem_two_ops(input logic [2:0] e);
    return (e != 3'd0) && (e != 3'd5);
  endfunction

  // Op k of element e is a read: first op of every element except M0.
  function automatic logic op_is_read(input logic [2:0] e, input logic k);
    return (e != 3'd0) && !k;
  endfunction

  // Data polarity of op k in element e (0 = background, 1 = inverted).
  function automatic logic op_pol(input logic [2:0] e, input logic k);
    case (e)
      3'd1, 3'd3: return k;
      3'd2, 3'd4: return !k;
      default:    return 1'b0;
    endcase
  endfunction

  // Descending-address elements.
  function automatic logic elem_down(input logic [2:0] e);
    return (e == 3'd3) || (e == 3'd4);
  endfunction

  // Bit i of the background: solid zero, or alternating (bit i = i[0])
  // inverted on odd addresses when the checkerboard pass is selected.
  function automatic logic bg_bit(input logic cb, input logic addr_odd, input int unsigned i);
    return cb & (i[0] ^ addr_odd);
  endfunction

endpackage

// File: rtl/march_bist_ctrl_addr_gen.sv
// March address generator: up/down counter with load-to-start, single step
// and a flag marking the last address of the current sweep direction.
module march_addr_gen #(
  parameter int unsigned ADDR_W = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              load_down,
  input  logic              step,
  input  logic              down,
  output logic [ADDR_W-1:0] addr,
  output logic              last
);

  // Address counter: load to the sweep start, or step one word.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr <= '0;
    end else if (load) begin
      addr <= load_down ? '1 : '0;
    end else if (step) begin
      addr <= down ? addr - ADDR_W'(1) : addr + ADDR_W'(1);
    end
  end

  // The sweep ends at the opposite end from where it started.
  always_comb begin
    last = down ? (addr == '0) : (addr == '1);
  end

endmodule

// File: rtl/march_bist_ctrl.sv
// March C- RAM BIST controller with first-fail logging and saturating error
// counter. Optional macro BIST_CHECKERBOARD_EN adds a second pass with a
// checkerboard background and a fail_bg output.
module march_bist_ctrl
  import march_bist_pkg::*;
#(
  parameter int unsigned ADDR_W = 2,
  parameter int unsigned DATA_W = 3,
  parameter int unsigned CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              ram_cs,
  output logic              ram_we,
  output logic              ram_oe,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [2:0]        fail_elem,
  output logic [DATA_W-1:0] fail_data,
  output logic [CNT_W-1:0]  err_count
`ifdef BIST_CHECKERBOARD_EN
  ,
  output logic              fail_bg
`endif
);

  state_t            state;
  logic [2:0]        elem;
  logic              op_idx;
  logic              bg_sel;
  logic [ADDR_W-1:0] gen_addr;
  logic              gen_last, gen_load, gen_load_down, gen_step, gen_down;
  logic              op_read, op_last, elem_end, last_elem, last_pass, run_end;
  logic              accept, mismatch;
  logic [2:0]        next_elem;
  logic [DATA_W-1:0] op_data;
  logic [CNT_W-1:0]  err_next;

  march_addr_gen #(.ADDR_W(ADDR_W)) u_addr_gen (
    .clk       (clk),
    .rst       (rst),
    .load      (gen_load),
    .load_down (gen_load_down),
    .step      (gen_step),
    .down      (gen_down),
    .addr      (gen_addr),
    .last      (gen_last)
  );

`ifdef BIST_CHECKERBOARD_EN
  assign last_pass = bg_sel;
`else
  assign last_pass = 1'b1;
`endif

  // Current-op decode, sequencing decisions and read check.
  always_comb begin
    accept    = start && (state != RUN);
    op_read   = op_is_read(elem, op_idx);
    for (int unsigned i = 0; i < DATA_W; i++) begin
      op_data[i] = bg_bit(bg_sel, gen_addr[0], i) ^ op_pol(elem, op_idx);
    end
    op_last   = !elem_two_ops(elem) || op_idx;
    elem_end  = op_last && gen_last;
    last_elem = (elem == 3'(NUM_ELEM - 1));
    run_end   = elem_end && last_elem && last_pass;
    next_elem = last_elem ? 3'd0 : elem + 3'd1;
    mismatch  = (state == RUN) && op_read && (ram_rdata != op_data);
    err_next  = (mismatch && (err_count != '1)) ? err_count + CNT_W'(1) : err_count;
    gen_down      = elem_down(elem);
    gen_load      = accept || ((state == RUN) && elem_end);
    gen_load_down = (state == RUN) && elem_down(next_elem);
    gen_step      = (state == RUN) && op_last && !gen_last;
  end

  // RAM bus is a decode of the registered op state; idle when not busy.
  always_comb begin
    ram_cs    = busy;
    ram_we    = busy && !op_read;
    ram_oe    = busy && op_read;
    ram_addr  = busy ? gen_addr : '0;
    ram_wdata = (busy && !op_read) ? op_data : '0;
  end

  // Control FSM with registered status and fail log.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      elem      <= '0;
      op_idx    <= 1'b0;
      bg_sel    <= 1'b0;
      err_count <= '0;
      fail_addr <= '0;
      fail_elem <= '0;
      fail_data <= '0;
`ifdef BIST_CHECKERBOARD_EN
      fail_bg   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state     <= RUN;
            busy      <= 1'b1;
            done      <= 1'b0;
            pass      <= 1'b0;
            elem      <= '0;
            op_idx    <= 1'b0;
            bg_sel    <= 1'b0;
            err_count <= '0;
            fail_addr <= '0;
            fail_elem <= '0;
            fail_data <= '0;
`ifdef BIST_CHECKERBOARD_EN
            fail_bg   <= 1'b0;
`endif
          end
        end
        RUN: begin
          err_count <= err_next;
          // err_count is still zero exactly until the first mismatch
          if (mismatch && (err_count == '0)) begin
            fail_addr <= gen_addr;
            fail_elem <= elem;
            fail_data <= ram_rdata;
`ifdef BIST_CHECKERBOARD_EN
            fail_bg   <= bg_sel;
`endif
          end
          if (!op_last) begin
            op_idx <= 1'b1;
          end else begin
            op_idx <= 1'b0;
            if (gen_last) begin
              if (run_end) begin
                state <= DONE;
                busy  <= 1'b0;
                done  <= 1'b1;
                pass  <= (err_next == '0);
                elem  <= '0;
              end else if (last_elem) begin
                elem   <= '0;
                bg_sel <= 1'b1;
              end else begin
                elem <= next_elem;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_march_bist_ctrl.sv
// Self-checking bench for march_bist_ctrl: a RAM with an optional stuck-at
// bit, and a reference model that walks the March C- element list directly.
module tb_march_bist_ctrl;

  localparam int ADDR_W = 2;
  localparam int DATA_W = 3;
  localparam int CNT_W  = 8;
  localparam int DEPTH  = 1 << ADDR_W;
`ifdef BIST_CHECKERBOARD_EN
  localparam int PASSES = 2;
  localparam int OUTS_W = 6 + 2 * ADDR_W + 2 * DATA_W + 3 + CNT_W + 1;
`else
  localparam int PASSES = 1;
  localparam int OUTS_W = 6 + 2 * ADDR_W + 2 * DATA_W + 3 + CNT_W;
`endif

`define CHK(TAG, OBS, EXP) \
  begin \
    checks++; \
    assert ((OBS) === (EXP)) else begin \
      failures++; \
      $error("FAIL %s observed=%0h expected=%0h", TAG, OBS, EXP); \
    end \
  end

  typedef struct packed {
    logic              cs;
    logic              we;
    logic              oe;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } bus_t;

  logic              clk, rst, start;
  logic              busy, done, pass, ram_cs, ram_we, ram_oe;
  logic [ADDR_W-1:0] ram_addr, fail_addr;
  logic [DATA_W-1:0] ram_wdata, ram_rdata, fail_data;
  logic [2:0]        fail_elem;
  logic [CNT_W-1:0]  err_count;
  logic              fail_bg_obs;
  logic [OUTS_W-1:0] all_outs;

  int checks = 0;
  int failures = 0;

  // RAM environment
  logic [DATA_W-1:0] mem [DEPTH];
  logic              scramble = 1'b0;
  logic              flt_en = 1'b0;
  int                flt_addr = 0, flt_bit = 0;
  logic              flt_val = 1'b0;

  // Reference model results
  bus_t              exp_q[$];
  logic [CNT_W-1:0]  exp_err;
  logic [ADDR_W-1:0] exp_faddr;
  logic [2:0]        exp_felem;
  logic [DATA_W-1:0] exp_fdata;
  logic              exp_fbg;

  string march [6] = '{"w0", "r0w1", "r1w0", "r0w1", "r1w0", "r0"};
  bit    march_down [6] = '{0, 0, 0, 1, 1, 0};

  march_bist_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata),
    .ram_cs    (ram_cs),
    .ram_we    (ram_we),
    .ram_oe    (ram_oe),
    .fail_addr (fail_addr),
    .fail_elem (fail_elem),
    .fail_data (fail_data),
    .err_count (err_count)
`ifdef BIST_CHECKERBOARD_EN
    ,
    .fail_bg   (fail_bg_obs)
`endif
  );

`ifdef BIST_CHECKERBOARD_EN
  assign all_outs = {busy, done, pass, ram_cs, ram_we, ram_oe, ram_addr, ram_wdata,
                     fail_addr, fail_elem, fail_data, err_count, fail_bg_obs};
`else
  assign fail_bg_obs = 1'b0;
  assign all_outs = {busy, done, pass, ram_cs, ram_we, ram_oe, ram_addr, ram_wdata,
                     fail_addr, fail_elem, fail_data, err_count};
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (scramble) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= DATA_W'($urandom);
    end else if (ram_cs && ram_we) begin
      mem[ram_addr] <= ram_wdata;
    end
  end

  always_comb begin
    ram_rdata = mem[ram_addr];
    if (flt_en && (int'(ram_addr) == flt_addr)) ram_rdata[flt_bit] = flt_val;
  end

  function automatic logic [DATA_W-1:0] bg_of(int p, int a);
    logic [DATA_W-1:0] b;
    for (int i = 0; i < DATA_W; i++) b[i] = (p == 1) ? (((i % 2) ^ (a % 2)) != 0) : 1'b0;
    return b;
  endfunction

  task automatic build_model(input bit fe, input int fa, input int fb, input logic fv);
    logic [DATA_W-1:0] m [DEPTH];
    logic [DATA_W-1:0] d, rv;
    bus_t op;
    int a;
    bit seen;
    exp_q.delete();
    exp_err = '0; exp_faddr = '0; exp_felem = '0; exp_fdata = '0; exp_fbg = 1'b0;
    seen = 0;
    for (int i = 0; i < DEPTH; i++) m[i] = mem[i];
    for (int p = 0; p < PASSES; p++)
      for (int e = 0; e < 6; e++)
        for (int s = 0; s < DEPTH; s++) begin
          a = march_down[e] ? DEPTH - 1 - s : s;
          for (int k = 0; k < march[e].len(); k += 2) begin
            d = bg_of(p, a) ^ {DATA_W{march[e][k+1] == "1"}};
            op.cs = 1'b1;
            op.addr = a[ADDR_W-1:0];
            if (march[e][k] == "w") begin
              op.we = 1'b1; op.oe = 1'b0; op.wdata = d;
              m[a] = d;
            end else begin
              op.we = 1'b0; op.oe = 1'b1; op.wdata = '0;
              rv = m[a];
              if (fe && a == fa) rv[fb] = fv;
              if (rv !== d) begin
                if (!seen) begin
                  seen = 1;
                  exp_faddr = a[ADDR_W-1:0];
                  exp_felem = e[2:0];
                  exp_fdata = rv;
                  exp_fbg = (p == 1);
                end
                if (exp_err != '1) exp_err++;
              end
            end
            exp_q.push_back(op);
          end
        end
  endtask

  task automatic run_march(input bit fe, input int fa, input int fb, input logic fv,
                           input bit restart, input int abort_at);
    bus_t obs, expo;
    int cyc;
    bit aborted;
    flt_en = fe; flt_addr = fa; flt_bit = fb; flt_val = fv;
    scramble = 1'b1;
    @(negedge clk);
    scramble = 1'b0;
    build_model(fe, fa, fb, fv);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    `CHK("busy_rise", busy, 1'b1)
    `CHK("start_clear", {done, pass, err_count}, {(CNT_W + 2){1'b0}})
    cyc = 0;
    aborted = 0;
    while (busy === 1'b1 && cyc < 1000) begin
      obs = {ram_cs, ram_we, ram_oe, ram_addr, (ram_we ? ram_wdata : {DATA_W{1'b0}})};
      expo = (cyc < exp_q.size()) ? exp_q[cyc] : '0;
      `CHK($sformatf("op%0d", cyc), obs, expo)
      cyc++;
      start = restart && (cyc == 5 || cyc == 20);
      rst = (cyc == abort_at);
      @(negedge clk);
      start = 1'b0;
      if (rst) begin
        rst = 1'b0;
        aborted = 1;
        break;
      end
    end
    if (aborted) begin
      `CHK("abort_outs", all_outs, {OUTS_W{1'b0}})
    end else begin
      `CHK("run_len", cyc, exp_q.size())
      `CHK("done", done, 1'b1)
      `CHK("pass", pass, (exp_err == '0))
      `CHK("err_count", err_count, exp_err)
      `CHK("fail_log", {fail_addr, fail_elem, fail_data}, {exp_faddr, exp_felem, exp_fdata})
`ifdef BIST_CHECKERBOARD_EN
      `CHK("fail_bg", fail_bg_obs, exp_fbg)
`endif
      `CHK("bus_idle", {ram_cs, ram_we, ram_oe}, 3'b000)
      repeat (3) @(negedge clk);
      `CHK("done_hold", {busy, done}, 2'b01)
    end
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    repeat (3) @(negedge clk);
    `CHK("reset_outs", all_outs, {OUTS_W{1'b0}})
    rst = 1'b0;
    @(negedge clk);

    // fault-free
    run_march(0, 0, 0, 1'b0, 0, -1);
    // bit 1 of address 2 stuck at 1
    run_march(1, 2, 1, 1'b1, 0, -1);
`ifndef BIST_CHECKERBOARD_EN
    `CHK("stuck_err3", err_count, 8'd3)
    `CHK("stuck_log", {fail_addr, fail_elem, fail_data}, {2'd2, 3'd1, 3'b010})
`endif
    // start re-issued while busy
    run_march(0, 0, 0, 1'b0, 1, -1);
    // reset mid-run then a fresh run
    run_march(1, 1, 0, 1'b1, 0, 12);
    `CHK("post_abort_idle", {busy, done}, 2'b00)
    run_march(0, 0, 0, 1'b0, 0, -1);
    // random stuck-at faults
    for (int r = 0; r < 5; r++) begin
      run_march(1, $urandom_range(0, DEPTH - 1), $urandom_range(0, DATA_W - 1),
                1'($urandom_range(0, 1)), 0, -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

`undef CHK

endmodule
